// File: rtl/slow_ctl.sv
// -----------------------------------------------------------------------------
// slow_ctl
//
// Slowdown request controller. Watches CPU bus cycles and peripheral chip
// selects and raises SlowReq while a slow-qualified peripheral is accessed.
// After the access ends, the request is held for SlowTimeout prescaler ticks.
// One tick lasts TICKDIV clock cycles.
//
// Parameters:
//   TICKDIV       CLK cycles per timeout tick (power of two, 2..256)
//
// Ports:
//   CLK           system clock; all logic runs on the rising edge
//   POR           synchronous active-high reset
//   BACT          CPU bus cycle active
//   IACKCS        interrupt-acknowledge cycle decoded
//   VIACS         VIA select
//   IWMCS         IWM select
//   SCCCS         SCC select
//   SCSICS        SCSI select
//   SndCS         sound buffer access
//   SlowIACK..SlowSnd  per-source slowdown enables
//   SlowClockGate gate-enable setting
//   SlowTimeout   hold-off length in ticks (sampled only at reload)
//   SlowReq       slowdown request to the clock switch (registered)
//   SlowGate      SlowReq && SlowClockGate (registered, aligned with SlowReq)
//   SlowCnt       current hold-off count (debug)
// -----------------------------------------------------------------------------
module slow_ctl #(
    parameter int TICKDIV = 64
) (
    input  logic       CLK,
    input  logic       POR,
    input  logic       BACT,
    input  logic       IACKCS,
    input  logic       VIACS,
    input  logic       IWMCS,
    input  logic       SCCCS,
    input  logic       SCSICS,
    input  logic       SndCS,
    input  logic       SlowIACK,
    input  logic       SlowVIA,
    input  logic       SlowIWM,
    input  logic       SlowSCC,
    input  logic       SlowSCSI,
    input  logic       SlowSnd,
    input  logic       SlowClockGate,
    input  logic [3:0] SlowTimeout,
    output logic       SlowReq,
    output logic       SlowGate,
    output logic [3:0] SlowCnt
);

    localparam int PW = (TICKDIV > 2) ? $clog2(TICKDIV) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [3:0]    cnt_q;
    logic [3:0]    cnt_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          bactr_q;
    logic          req_q;
    logic          gate_q;

    logic          hit_s;
    logic          access_end_s;
    logic          tick_s;
    logic          hold_entry_s;
    logic          req_d_s;

    // Decode a slow-qualified access; only meaningful while a bus cycle is active.
    always_comb begin
        hit_s = BACT && ((IACKCS && SlowIACK) ||
                         (VIACS  && SlowVIA)  ||
                         (IWMCS  && SlowIWM)  ||
                         (SCCCS  && SlowSCC)  ||
                         (SCSICS && SlowSCSI) ||
                         (SndCS  && SlowSnd));
        access_end_s = !BACT && bactr_q;
        // TICKDIV is a power of two, so the wrap point is the all-ones value.
        tick_s = (presc_q == {PW{1'b1}});
    end

    // Next-state and hold-off count logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hit_s) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Enables are not re-checked here: only the bus cycle end exits.
                if (access_end_s) begin
                    cnt_d = SlowTimeout;
                    if (SlowTimeout == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_HOLD: begin
                // A new slow hit takes priority over a coincident tick.
                if (hit_s) begin
                    state_d = ST_ACCESS;
                end else if (tick_s && (cnt_q != 4'd0)) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else if (cnt_q == 4'd0) begin
                    // Unreachable in normal operation; never sit in HOLD with nothing to drain.
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Prescaler restarts on HOLD entry so the first drain tick is a full period away.
    always_comb begin
        hold_entry_s = (state_q == ST_ACCESS) && (state_d == ST_HOLD);
        if (hold_entry_s) begin
            presc_d = {PW{1'b0}};
        end else begin
            presc_d = presc_q + PW'(1);
        end
        req_d_s = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (POR) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            presc_q <= {PW{1'b0}};
            bactr_q <= 1'b0;
            req_q   <= 1'b0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            bactr_q <= BACT;
            req_q   <= req_d_s;
            gate_q  <= req_d_s && SlowClockGate;
        end
    end

    assign SlowReq  = req_q;
    assign SlowGate = gate_q;
    assign SlowCnt  = cnt_q;

endmodule

// File: tb/tb_slow_ctl.sv
// -----------------------------------------------------------------------------
// tb_slow_ctl
//
// Self-checking bench for slow_ctl. A behavioural reference model predicts
// SlowReq/SlowGate/SlowCnt for every clock; the prediction is queued when the
// stimulus is driven and popped/compared after the clock edge.
// -----------------------------------------------------------------------------
module tb_slow_ctl;

    localparam int TICKDIV = 64;

    logic       CLK = 1'b0;
    logic       POR, BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS;
    logic       SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd;
    logic       SlowClockGate;
    logic [3:0] SlowTimeout;
    logic       SlowReq, SlowGate;
    logic [3:0] SlowCnt;

    slow_ctl #(.TICKDIV(TICKDIV)) dut (
        .CLK          (CLK),
        .POR          (POR),
        .BACT         (BACT),
        .IACKCS       (IACKCS),
        .VIACS        (VIACS),
        .IWMCS        (IWMCS),
        .SCCCS        (SCCCS),
        .SCSICS       (SCSICS),
        .SndCS        (SndCS),
        .SlowIACK     (SlowIACK),
        .SlowVIA      (SlowVIA),
        .SlowIWM      (SlowIWM),
        .SlowSCC      (SlowSCC),
        .SlowSCSI     (SlowSCSI),
        .SlowSnd      (SlowSnd),
        .SlowClockGate(SlowClockGate),
        .SlowTimeout  (SlowTimeout),
        .SlowReq      (SlowReq),
        .SlowGate     (SlowGate),
        .SlowCnt      (SlowCnt)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       req;
        logic       gate;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: 0 idle, 1 access, 2 hold; m_age counts cycles spent in hold
    int m_state = 0;
    int m_cnt   = 0;
    int m_age   = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Advance the model with the currently driven inputs, queue the prediction,
    // clock the DUT, then pop and compare.
    task automatic step();
        exp_t e;
        bit   hit;
        bit   tick;
        if (POR) begin
            m_state = 0;
            m_cnt   = 0;
            m_age   = 0;
        end else begin
            hit = BACT && ((IACKCS && SlowIACK) || (VIACS && SlowVIA) ||
                           (IWMCS && SlowIWM) || (SCCCS && SlowSCC) ||
                           (SCSICS && SlowSCSI) || (SndCS && SlowSnd));
            tick = (m_state == 2) && ((m_age % TICKDIV) == TICKDIV - 1);
            case (m_state)
                0: if (hit) m_state = 1;
                1: begin
                    if (!BACT) begin
                        m_cnt = int'(SlowTimeout);
                        if (SlowTimeout == 4'd0) begin
                            m_state = 0;
                        end else begin
                            m_state = 2;
                            m_age   = 0;
                        end
                    end
                end
                2: begin
                    m_age++;
                    if (hit) begin
                        m_state = 1;
                    end else if (tick) begin
                        m_cnt--;
                        if (m_cnt == 0) m_state = 0;
                    end
                end
                default: m_state = 0;
            endcase
        end
        e.req  = (m_state != 0);
        e.gate = e.req && SlowClockGate;
        e.cnt  = 4'(m_cnt);
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        e = sb_q.pop_front();
        chk("SlowReq",  int'(SlowReq),  int'(e.req));
        chk("SlowGate", int'(SlowGate), int'(e.gate));
        chk("SlowCnt",  int'(SlowCnt),  int'(e.cnt));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_idle();
        BACT = 1'b0; IACKCS = 1'b0; VIACS = 1'b0; IWMCS = 1'b0;
        SCCCS = 1'b0; SCSICS = 1'b0; SndCS = 1'b0;
    endtask

    // Step until SlowReq drops; returns steps taken, capped by budget.
    task automatic drain(input int budget, output int n);
        n = 0;
        while (SlowReq && n < budget) begin
            step();
            n++;
        end
    endtask

    // Step until SlowCnt reaches target or budget runs out.
    task automatic wait_cnt(input int target, input int budget);
        int n;
        n = 0;
        while (int'(SlowCnt) != target && n < budget) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        bit seen;

        POR = 1'b1;
        bus_idle();
        SlowIACK = 1'b0; SlowVIA = 1'b0; SlowIWM = 1'b0;
        SlowSCC = 1'b0; SlowSCSI = 1'b0; SlowSnd = 1'b0;
        SlowClockGate = 1'b1;
        SlowTimeout = 4'd0;

        // reset state
        steps(2);
        chk("reset_req", int'(SlowReq), 0);
        chk("reset_gate", int'(SlowGate), 0);
        chk("reset_cnt", int'(SlowCnt), 0);
        POR = 1'b0;
        steps(3);

        // VIA access, timeout 3, enable dropped mid-access
        SlowVIA = 1'b1; SlowTimeout = 4'd3;
        BACT = 1'b1; VIACS = 1'b1;
        step();
        chk("via_req_rise", int'(SlowReq), 1);
        for (int i = 0; i < 9; i++) begin
            if (i == 4) SlowVIA = 1'b0;
            step();
        end
        chk("via_hold_after_disable", int'(SlowReq), 1);
        bus_idle();
        step();
        chk("via_cnt_load", int'(SlowCnt), 3);
        drain(1000, n);
        chk("via_drain_len", n + 1, 3 * TICKDIV + 1);
        chk("via_cnt_end", int'(SlowCnt), 0);
        steps(2);

        // SCSI disabled, then enabled with timeout 0
        SlowSCSI = 1'b0;
        BACT = 1'b1; SCSICS = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen |= SlowReq;
        end
        bus_idle();
        step();
        seen |= SlowReq;
        chk("scsi_disabled_req", int'(seen), 0);
        SlowSCSI = 1'b1; SlowTimeout = 4'd0;
        BACT = 1'b1; SCSICS = 1'b1;
        steps(5);
        chk("scsi_t0_active", int'(SlowReq), 1);
        bus_idle();
        step();
        chk("scsi_t0_fall", int'(SlowReq), 0);
        steps(3);

        // back-to-back: IWM, SCC hit mid-hold, then a ROM cycle during hold
        SlowIWM = 1'b1; SlowSCC = 1'b1; SlowTimeout = 4'd5;
        BACT = 1'b1; IWMCS = 1'b1;
        steps(4);
        bus_idle();
        step();
        wait_cnt(2, 1000);
        chk("b2b_reach2", int'(SlowCnt), 2);
        BACT = 1'b1; SCCCS = 1'b1;
        steps(3);
        chk("b2b_access_cnt_held", int'(SlowCnt), 2);
        bus_idle();
        step();
        chk("b2b_reload", int'(SlowCnt), 5);
        wait_cnt(4, 1000);
        BACT = 1'b1;
        steps(4);
        bus_idle();
        step();
        chk("rom_no_reload", int'(SlowCnt), 4);
        drain(1000, n);
        chk("b2b_drain_done", int'(SlowReq), 0);
        steps(2);

        // SlowClockGate off, then on
        SlowTimeout = 4'd0; SlowClockGate = 1'b0;
        BACT = 1'b1; IWMCS = 1'b1;
        steps(3);
        chk("gate_off_req", int'(SlowReq), 1);
        chk("gate_off", int'(SlowGate), 0);
        bus_idle();
        step();
        SlowClockGate = 1'b1;
        BACT = 1'b1; IWMCS = 1'b1;
        steps(3);
        chk("gate_on", int'(SlowGate), 1);
        bus_idle();
        steps(2);

        // POR in hold, then release with a VIA access already active
        SlowTimeout = 4'd3;
        BACT = 1'b1; IWMCS = 1'b1;
        steps(2);
        bus_idle();
        step();
        wait_cnt(2, 1000);
        POR = 1'b1;
        step();
        chk("por_req", int'(SlowReq), 0);
        chk("por_cnt", int'(SlowCnt), 0);
        SlowVIA = 1'b1; BACT = 1'b1; VIACS = 1'b1;
        step();
        chk("por_held_req", int'(SlowReq), 0);
        POR = 1'b0;
        step();
        chk("por_release_req", int'(SlowReq), 1);
        SlowTimeout = 4'd0;
        bus_idle();
        steps(2);

        // SlowTimeout changed during hold only takes effect at the next reload
        SlowTimeout = 4'd3;
        BACT = 1'b1; VIACS = 1'b1;
        steps(3);
        bus_idle();
        step();
        steps(10);
        SlowTimeout = 4'd9;
        drain(1000, n);
        chk("tmo_change_len", n + 11, 3 * TICKDIV + 1);
        BACT = 1'b1; VIACS = 1'b1;
        steps(2);
        bus_idle();
        step();
        chk("tmo_new_reload", int'(SlowCnt), 9);
        drain(1000, n);
        chk("tmo_new_len", n + 1, 9 * TICKDIV + 1);

        // random traffic against the model
        SlowTimeout = 4'd1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 5) == 0) BACT = ~BACT;
            IACKCS = 1'($urandom_range(0, 7) == 0);
            VIACS  = 1'($urandom_range(0, 7) == 0);
            IWMCS  = 1'($urandom_range(0, 7) == 0);
            SCCCS  = 1'($urandom_range(0, 7) == 0);
            SCSICS = 1'($urandom_range(0, 7) == 0);
            SndCS  = 1'($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) begin
                SlowIACK = 1'($urandom_range(0, 1)); SlowVIA = 1'($urandom_range(0, 1));
                SlowIWM  = 1'($urandom_range(0, 1)); SlowSCC = 1'($urandom_range(0, 1));
                SlowSCSI = 1'($urandom_range(0, 1)); SlowSnd = 1'($urandom_range(0, 1));
                SlowClockGate = 1'($urandom_range(0, 1));
                SlowTimeout = 4'($urandom_range(0, 2));
            end
            POR = 1'($urandom_range(0, 299) == 0);
            step();
        end
        POR = 1'b0;
        bus_idle();
        steps(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
